// File: rtl/sc_config_bank_if.sv
// sc_config_bank_if: Avalon-MM slave bus between the Nios CPU and sc_config_bank
interface sc_config_bank_if #(
  parameter int ADDR_W = 4
);
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              write;
  logic              read;
  logic              chipselect;
  logic              waitrequest_n;
  modport master (
    output writedata, address, byteenable, write, read, chipselect,
    input  readdata, readdatavalid, waitrequest_n
  );
  modport slave (
    input  writedata, address, byteenable, write, read, chipselect,
    output readdata, readdatavalid, waitrequest_n
  );
endinterface

// File: rtl/sc_config_bank.sv
// sc_config_bank: double-buffered Avalon-MM config/status bank, commits shadow->active on vsync rise
// SC_CONFIG_READBACK_EN: config reads return shadow words and CTRL exposes the pending bit
module sc_config_bank #(
  parameter int NUM_STATUS = 2,
  parameter int NUM_CONFIG = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  sc_config_bank_if.slave          avalon_s,
  input  logic [NUM_STATUS*32-1:0] status_i,
  input  logic                     vsync_i,
  output logic [NUM_CONFIG*32-1:0] cfg_o,
  output logic                     commit_done_o
);
  localparam int CA = NUM_STATUS + NUM_CONFIG;
  if (2**ADDR_W <= CA) begin : g_addr_chk
    $error("sc_config_bank: ADDR_W too small for the register map");
  end
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_e;
  state_e                   state, state_n;
  logic [NUM_CONFIG*32-1:0] shadow;
  logic [NUM_STATUS*32-1:0] status_snap;
  logic                     imm, vsync_q, vs_rise, wr, rd, ctrl_wr, req;
  logic [31:0]              rdata;
  assign vs_rise  = vsync_i & ~vsync_q;
  assign wr       = avalon_s.chipselect & avalon_s.write;
  assign rd       = avalon_s.chipselect & avalon_s.read;
  assign ctrl_wr  = wr & (avalon_s.address == ADDR_W'(CA)) & avalon_s.byteenable[0];
  assign req      = ctrl_wr & avalon_s.writedata[0];
  assign avalon_s.waitrequest_n = 1'b1;
  // a request arriving in COMMIT re-arms instead of being lost
  always_comb begin
    state_n = (state == IDLE)    ? (req ? PENDING : IDLE) :
              (state == PENDING) ? (vs_rise ? COMMIT : PENDING) :
                                   (req ? PENDING : IDLE);
  end
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_STATUS; k++)
      if (avalon_s.address == ADDR_W'(k)) rdata = status_snap[32*k +: 32];
`ifdef SC_CONFIG_READBACK_EN
    for (int k = 0; k < NUM_CONFIG; k++)
      if (avalon_s.address == ADDR_W'(NUM_STATUS + k)) rdata = shadow[32*k +: 32];
    if (avalon_s.address == ADDR_W'(CA)) rdata = {29'b0, imm, state == PENDING, 1'b0};
`else
    if (avalon_s.address == ADDR_W'(CA)) rdata = {29'b0, imm, 2'b0};
`endif
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state                  <= IDLE;
      shadow                 <= '0;
      cfg_o                  <= '0;
      status_snap            <= '0;
      imm                    <= 1'b0;
      vsync_q                <= 1'b1;
      commit_done_o          <= 1'b0;
      avalon_s.readdata      <= '0;
      avalon_s.readdatavalid <= 1'b0;
    end else begin
      state   <= state_n;
      vsync_q <= vsync_i;
      if (vs_rise) status_snap <= status_i;
      if (ctrl_wr) imm <= avalon_s.writedata[2];
      for (int k = 0; k < NUM_CONFIG; k++)
        for (int b = 0; b < 4; b++)
          if (wr && avalon_s.address == ADDR_W'(NUM_STATUS + k) && avalon_s.byteenable[b])
            shadow[32*k + 8*b +: 8] <= avalon_s.writedata[8*b +: 8];
      if (imm || state == COMMIT) cfg_o <= shadow;
      commit_done_o          <= state == COMMIT;
      avalon_s.readdata      <= rd ? rdata : '0;
      avalon_s.readdatavalid <= rd;
    end
  end
endmodule

// File: tb/tb_sc_config_bank.sv
// tb_sc_config_bank: directed scoreboard bench for sc_config_bank
module tb_sc_config_bank;
  logic         clk_i = 1'b0, rst_ni = 1'b0, vsync_i = 1'b1;
  logic [63:0]  status_i = '0;
  logic [255:0] cfg_o;
  logic         commit_done_o;
  int           tests = 0, fails = 0;
  logic [31:0]  rd_q[$];
  logic [255:0] cm_q[$];
  logic [255:0] exp_cfg = '0;
`ifdef SC_CONFIG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  sc_config_bank_if #(.ADDR_W(4)) bus();
  sc_config_bank #(.NUM_STATUS(2), .NUM_CONFIG(8), .ADDR_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .avalon_s(bus.slave), .status_i(status_i),
    .vsync_i(vsync_i), .cfg_o(cfg_o), .commit_done_o(commit_done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk_i) if (rst_ni === 1'b1) begin
    if (bus.readdatavalid === 1'b1) begin
      if (rd_q.size() == 0) check("unexpected readdatavalid", bus.readdatavalid, 1'b0);
      else check("readdata", bus.readdata, rd_q.pop_front());
    end
    if (commit_done_o === 1'b1) begin
      if (cm_q.size() == 0) check("unexpected commit_done", commit_done_o, 1'b0);
      else check("cfg at commit", cfg_o, cm_q.pop_front());
    end
  end
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d; bus.byteenable = be;
    idle(1);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    idle(1);
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask
  task automatic vs_pulse();
    vsync_i = 1'b1;
    idle(1);
    vsync_i = 1'b0;
    idle(3);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0; bus.byteenable = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset cfg_o", cfg_o, '0);
    check("reset readdatavalid", bus.readdatavalid, 1'b0);
    check("reset commit_done", commit_done_o, 1'b0);
    rst_ni = 1'b1;
    idle(3);
    check("post-reset cfg_o", cfg_o, '0);
    check("waitrequest_n", bus.waitrequest_n, 1'b1);
    vsync_i = 1'b0;
    idle(2);
    wr(4'd2, 32'hAABBCCDD, 4'b0101);
    wr(4'd10, 32'h1, 4'hF);
    exp_cfg[31:0] = 32'h00BB00DD;
    cm_q.push_back(exp_cfg);
    vs_pulse();
    check("word0 after commit", cfg_o[31:0], 32'h00BB00DD);
    wr(4'd3, 32'h12345678, 4'hF);
    repeat (3) vs_pulse();
    check("word1 without commit", cfg_o[63:32], 32'h0);
    wr(4'd10, 32'h1, 4'hF);
    exp_cfg[63:32] = 32'h12345678;
    cm_q.push_back(exp_cfg);
    vs_pulse();
    check("word1 after commit", cfg_o[63:32], 32'h12345678);
    wr(4'd5, 32'h0000CAFE, 4'hF);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd10; bus.writedata = 32'h1; bus.byteenable = 4'hF;
    vsync_i = 1'b1;
    idle(1);
    bus.chipselect = 1'b0; bus.write = 1'b0; vsync_i = 1'b0;
    idle(3);
    check("word3 same-cycle request", cfg_o[127:96], 32'h0);
    exp_cfg[127:96] = 32'h0000CAFE;
    cm_q.push_back(exp_cfg);
    vs_pulse();
    check("word3 next frame", cfg_o[127:96], 32'h0000CAFE);
    wr(4'd10, 32'h1, 4'hF);
    wr(4'd10, 32'h1, 4'hF);
    cm_q.push_back(exp_cfg);
    vs_pulse();
    idle(3);
    status_i = {32'h77, 32'h55};
    vs_pulse();
    status_i = {32'h88, 32'h66};
    rd(4'd0, 32'h55);
    rd(4'd1, 32'h77);
    rd(4'd15, 32'h0);
    rd(4'd10, 32'h0);
    rd(4'd2, RB ? 32'h00BB00DD : 32'h0);
    idle(2);
    wr(4'd10, 32'h4, 4'hF);
    wr(4'd4, 32'hFF, 4'hF);
    check("imm word2 before edge", cfg_o[95:64], 32'h0);
    idle(1);
    check("imm word2 one clk later", cfg_o[95:64], 32'hFF);
    exp_cfg[95:64] = 32'hFF;
    rd(4'd4, RB ? 32'hFF : 32'h0);
    rd(4'd10, 32'h4);
    wr(4'd10, 32'h5, 4'hF);
    cm_q.push_back(exp_cfg);
    vs_pulse();
    wr(4'd10, 32'h1, 4'hF);
    rd(4'd10, RB ? 32'h2 : 32'h0);
    cm_q.push_back(exp_cfg);
    vs_pulse();
    idle(5);
    check("reads outstanding", rd_q.size(), 0);
    check("commits outstanding", cm_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
